axi_lite_slave_if: RTL and testbench

AXI4-Lite slave front-end for the PL register/table space. It accepts write and read transactions from the PS general-purpose port and presents them as simple level-held requests (we/waddr/wdata, re/raddr) to the downstream address decoder. It waits for that decoder's done strobes and returns B/R responses. A per-access timeout converts unmapped or stalled accesses into SLVERR so the bus never hangs.

---
 rtl/axi_lite_slave_if.sv | 196 +++++++++++++++++++
 tb/tb_axi_lite_slave_if.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite slave front-end: turns AW/W/AR bursts into level-held we/re requests and
// returns B/R responses on decoder done strobes, converting stalls into SLVERR after TIMEOUT.
module axi_lite_slave_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic              wdone,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rdone
);
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} rd_state_e;

  // Last EXEC cycle count; a 1-cycle TIMEOUT gives up on the first EXEC cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic              en_q;
  wr_state_e         wst_q, wst_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [1:0]        bresp_q, bresp_d;

  rd_state_e         rst_q, rst_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [1:0]        rresp_q, rresp_d;

  always_comb begin
    wst_d         = wst_q;
    aw_got_d      = aw_got_q;
    w_got_d       = w_got_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    wcnt_d        = wcnt_q;
    bresp_d       = bresp_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    unique case (wst_q)
      W_IDLE: begin
        s_axi_awready = en_q && !aw_got_q;
        s_axi_wready  = en_q && !w_got_q;
        if (s_axi_awvalid && s_axi_awready) begin
          aw_got_d = 1'b1;
          waddr_d  = s_axi_awaddr;
        end
        if (s_axi_wvalid && s_axi_wready) begin
          w_got_d = 1'b1;
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
        end
        if (aw_got_d && w_got_d) begin
          wcnt_d = 8'd0;
          if (wstrb_d == 4'hF) begin
            wst_d = W_EXEC;
          end else begin
            wst_d   = W_RESP;
            bresp_d = 2'b10;
          end
        end
      end
      W_EXEC: begin
        wcnt_d = wcnt_q + 8'd1;
        if (wdone) begin
          wst_d   = W_RESP;
          bresp_d = 2'b00;
        end else if (wcnt_q == CNT_LAST) begin
          wst_d   = W_RESP;
          bresp_d = 2'b10;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wst_d    = W_IDLE;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          wcnt_d   = 8'd0;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    rst_d         = rst_q;
    raddr_d       = raddr_q;
    rdata_d       = rdata_q;
    rcnt_d        = rcnt_q;
    rresp_d       = rresp_q;
    s_axi_arready = 1'b0;
    unique case (rst_q)
      R_IDLE: begin
        s_axi_arready = en_q;
        if (s_axi_arvalid && s_axi_arready) begin
          raddr_d = s_axi_araddr;
          rcnt_d  = 8'd0;
          rst_d   = R_EXEC;
        end
      end
      R_EXEC: begin
        rcnt_d = rcnt_q + 8'd1;
        if (rdone) begin
          rdata_d = rdata;
          rresp_d = 2'b00;
          rst_d   = R_RESP;
        end else if (rcnt_q == CNT_LAST) begin
          rdata_d = '0;
          rresp_d = 2'b10;
          rst_d   = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rst_d  = R_IDLE;
          rcnt_d = 8'd0;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  // en_q holds the ready outputs low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      wst_q    <= W_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= 4'h0;
      wcnt_q   <= 8'd0;
      bresp_q  <= 2'b00;
      rst_q    <= R_IDLE;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rcnt_q   <= 8'd0;
      rresp_q  <= 2'b00;
    end else begin
      en_q     <= 1'b1;
      wst_q    <= wst_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wcnt_q   <= wcnt_d;
      bresp_q  <= bresp_d;
      rst_q    <= rst_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      rcnt_q   <= rcnt_d;
      rresp_q  <= rresp_d;
    end
  end

  assign we           = (wst_q == W_EXEC);
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign s_axi_bvalid = (wst_q == W_RESP);
  assign s_axi_bresp  = bresp_q;
  assign re           = (rst_q == R_EXEC);
  assign raddr        = raddr_q;
  assign s_axi_rvalid = (rst_q == R_RESP);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
endmodule

// File: tb/tb_axi_lite_slave_if.sv
// Directed bench for axi_lite_slave_if: write/read vector tables plus hand sequences
// for concurrency, spurious strobes, reset release and asynchronous reset mid-transaction.
module tb_axi_lite_slave_if;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        wdone = 1'b0;
  logic        re;
  logic [31:0] raddr;
  logic [31:0] dec_rdata = '0;
  logic        rdone = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_lite_slave_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .we(we), .waddr(waddr), .wdata(wdata), .wdone(wdone),
    .re(re), .raddr(raddr), .rdata(dec_rdata), .rdone(rdone)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          wdone_at;   // k-th we cycle carries wdone; 0 = never
    int          bready_dly;
    logic [1:0]  exp_resp;
    int          exp_we;
  } wvec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          rdone_at;   // k-th re cycle carries rdone; 0 = never
    int          rready_dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_re;
  } rvec_t;

  wvec_t wv[5];
  rvec_t rv[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_write(input wvec_t v, input string nm);
    int c = 0, aw_c = -1, w_c = -1, we_c = 0, first_b = -1, b_c = 0;
    bit aw_f = 0, w_f = 0, b_f = 0, aw_done = 0, w_done = 0, done = 0, stable = 1;
    logic [1:0] resp0 = 2'b00;
    while (!done && c < 400) begin
      @(negedge clk);
      if (aw_f) begin aw_done = 1; aw_f = 0; end
      if (w_f) begin w_done = 1; w_f = 0; end
      if (b_f) begin
        done = 1;
        chk({nm, " bvalid_after_hs"}, {31'd0, s_axi_bvalid}, 32'd0);
      end else begin
        if (we) begin
          if (we_c == 0) begin
            chk({nm, " waddr"}, waddr, v.addr);
            chk({nm, " wdata"}, wdata, v.data);
          end
          we_c++;
        end
        if (s_axi_bvalid) begin
          if (first_b < 0) begin first_b = c; resp0 = s_axi_bresp; end
          else if (s_axi_bresp !== resp0) stable = 0;
          b_c++;
        end else if (first_b >= 0) stable = 0;
        s_axi_awvalid = !aw_done && c >= v.aw_dly;
        s_axi_awaddr  = s_axi_awvalid ? v.addr : 32'h0;
        s_axi_wvalid  = !w_done && c >= v.w_dly;
        s_axi_wdata   = s_axi_wvalid ? v.data : 32'h0;
        s_axi_wstrb   = s_axi_wvalid ? v.strb : 4'h0;
        wdone         = we && v.wdone_at != 0 && we_c == v.wdone_at;
        s_axi_bready  = s_axi_bvalid && b_c > v.bready_dly;
        aw_f = s_axi_awvalid && s_axi_awready;
        w_f  = s_axi_wvalid && s_axi_wready;
        b_f  = s_axi_bvalid && s_axi_bready;
        if (aw_f) aw_c = c;
        if (w_f) w_c = c;
      end
      c++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; wdone = 0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s write_timeout: got no B handshake expected one within 400 cycles", nm);
    end else begin
      chk({nm, " we_cycles"}, we_c, v.exp_we);
      chk({nm, " b_latency"}, first_b - ((aw_c > w_c) ? aw_c : w_c), v.exp_we + 1);
      chk({nm, " bresp"}, {30'd0, resp0}, {30'd0, v.exp_resp});
      chk({nm, " bvalid_cycles"}, b_c, v.bready_dly + 1);
      chk({nm, " b_stable"}, {31'd0, stable}, 32'd1);
    end
  endtask

  task automatic do_read(input rvec_t v, input string nm);
    int c = 0, hs_c = -1, re_c = 0, first_v = -1, v_c = 0;
    bit ar_f = 0, r_f = 0, ar_done = 0, done = 0, stable = 1;
    logic [31:0] d0 = '0;
    logic [1:0]  r0 = '0;
    while (!done && c < 400) begin
      @(negedge clk);
      if (ar_f) begin ar_done = 1; ar_f = 0; end
      if (r_f) begin
        done = 1;
        chk({nm, " rvalid_after_hs"}, {31'd0, s_axi_rvalid}, 32'd0);
      end else begin
        if (re) begin
          if (re_c == 0) chk({nm, " raddr"}, raddr, v.addr);
          re_c++;
        end
        if (s_axi_rvalid) begin
          if (first_v < 0) begin first_v = c; d0 = s_axi_rdata; r0 = s_axi_rresp; end
          else if (s_axi_rdata !== d0 || s_axi_rresp !== r0) stable = 0;
          v_c++;
        end else if (first_v >= 0) stable = 0;
        s_axi_arvalid = !ar_done;
        s_axi_araddr  = s_axi_arvalid ? v.addr : 32'h0;
        rdone         = re && v.rdone_at != 0 && re_c == v.rdone_at;
        dec_rdata     = rdone ? v.data : 32'hBAD0_BAD0;
        s_axi_rready  = s_axi_rvalid && v_c > v.rready_dly;
        ar_f = s_axi_arvalid && s_axi_arready;
        r_f  = s_axi_rvalid && s_axi_rready;
        if (ar_f) hs_c = c;
      end
      c++;
    end
    s_axi_arvalid = 0; s_axi_rready = 0; rdone = 0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s read_timeout: got no R handshake expected one within 400 cycles", nm);
    end else begin
      chk({nm, " re_cycles"}, re_c, v.exp_re);
      chk({nm, " r_latency"}, first_v - hs_c, v.exp_re + 1);
      chk({nm, " rdata"}, d0, v.exp_rdata);
      chk({nm, " rresp"}, {30'd0, r0}, {30'd0, v.exp_resp});
      chk({nm, " rvalid_cycles"}, v_c, v.rready_dly + 1);
      chk({nm, " r_stable"}, {31'd0, stable}, 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected one before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    //          addr           data          strb  awd wd done brd resp  we
    wv[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 3,   2, 2'b00, 3};
    wv[1] = '{32'h8000_0004, 32'hCAFE_0001, 4'hF, 3, 0, 1,   0, 2'b00, 1};
    wv[2] = '{32'hC000_0000, 32'h1111_2222, 4'hF, 0, 0, 0,   0, 2'b10, 255};
    wv[3] = '{32'h0000_0020, 32'h55AA_55AA, 4'h3, 0, 0, 0,   0, 2'b10, 0};
    wv[4] = '{32'h0000_0044, 32'h0102_0304, 4'hF, 0, 2, 2,   1, 2'b00, 2};
    //          addr           data          done rrd resp   exp_rdata      re
    rv[0] = '{32'h0000_0008, 32'h1234_5678, 2,   5, 2'b00, 32'h1234_5678, 2};
    rv[1] = '{32'hFFFF_0000, 32'h9999_9999, 0,   0, 2'b10, 32'h0000_0000, 255};
    rv[2] = '{32'h0000_0004, 32'hA5A5_0F0F, 1,   0, 2'b00, 32'hA5A5_0F0F, 1};

    repeat (3) @(negedge clk);
    chk("rst awready", {31'd0, s_axi_awready}, 32'd0);
    chk("rst arready", {31'd0, s_axi_arready}, 32'd0);
    chk("rst bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    chk("rst rvalid", {31'd0, s_axi_rvalid}, 32'd0);
    chk("rst we_re", {30'd0, we, re}, 32'd0);
    chk("rst rdata", s_axi_rdata, 32'd0);
    rst = 0;
    #1;
    chk("release wready", {31'd0, s_axi_wready}, 32'd0);
    @(negedge clk);
    chk("post_release readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

    // Decoder strobes while idle must be ignored.
    wdone = 1; rdone = 1; dec_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    wdone = 0; rdone = 0;
    chk("spurious bvalid_rvalid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    chk("spurious readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

    for (int i = 0; i < 5; i++) do_write(wv[i], $sformatf("wr%0d", i));
    for (int i = 0; i < 3; i++) do_read(rv[i], $sformatf("rd%0d", i));

    fork
      do_read(rv[0], "conc_rd");
      do_write(wv[4], "conc_wr");
    join

    // Asynchronous reset with the write in EXEC and the read in RESP.
    @(negedge clk);
    s_axi_awvalid = 1; s_axi_awaddr = 32'h100; s_axi_wvalid = 1;
    s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF;
    s_axi_arvalid = 1; s_axi_araddr = 32'h200;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    chk("mid we_re", {30'd0, we, re}, 32'd3);
    rdone = 1; dec_rdata = 32'h99;
    @(negedge clk);
    rdone = 0;
    chk("mid we_rvalid", {30'd0, we, s_axi_rvalid}, 32'd3);
    #2 rst = 1;
    #1;
    chk("async we_re", {30'd0, we, re}, 32'd0);
    chk("async bvalid_rvalid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    chk("async rdata", s_axi_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rerelease awready", {31'd0, s_axi_awready}, 32'd0);
    do_write(wv[0], "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
